// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU.
// Single-cycle logic/arithmetic/compare ops finish one clock after acceptance.
// Multi-bit shifts step one bit per clock behind a start/ready/done handshake.
// Carry and compare flags persist in registers between instructions.
// Optional feature: define SEQ_ALU_MUL_EN to build the iterative radix-2
// multiplier on opcode 10 (MUL state, accumulator and result_hi driver).
// Without it, opcode 10 is an unused opcode and result_hi is tied to zero.

module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             use_carry,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_q,
  output logic [1:0]       cmp_flag
);

  // Operation codes
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MOVB = 4'd5;
  localparam logic [3:0] OP_MOVA = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif
  localparam logic [3:0] OP_CLRC = 4'd11;

  // Compare flag encodings
  localparam logic [1:0] CMP_NONE = 2'b11;
  localparam logic [1:0] CMP_EQ   = 2'b10;
  localparam logic [1:0] CMP_GT   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b00;

  // Step counter constants
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t state_q;
  state_t state_d;

  // Iteration state
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] work_q;
  logic             shl_q;
  logic             uc_q;

  // Acceptance decode
  logic             accept;
  logic [CNTW-1:0]  raw_n;
  logic [CNTW-1:0]  shift_n;
  logic             is_shift_op;
  logic             start_shift;
  logic             last_step;
  logic             finish_other;

  // Shift step datapath
  logic             fill;
  logic             shift_out;
  logic [WIDTH-1:0] shifted;

  // Single-cycle datapath
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;
  logic [1:0]       sc_cmp;

`ifdef SEQ_ALU_MUL_EN
  logic             start_mul;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mul_hi_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_d;
  logic [WIDTH-1:0] mul_lo_d;
`endif

  assign accept      = start && ready;
  assign raw_n       = in_b[CNTW-1:0];
  assign shift_n     = (raw_n > CNT_FULL) ? CNT_FULL : raw_n;
  assign is_shift_op = (op == OP_SHL) || (op == OP_SHR);
  assign start_shift = accept && is_shift_op && (shift_n != '0);
  assign last_step   = (cnt_q == CNT_ONE);

`ifdef SEQ_ALU_MUL_EN
  assign start_mul    = accept && (op == OP_MUL);
  assign finish_other = ((state_q == IDLE) && accept && !start_shift && !start_mul) ||
                        ((state_q == SHIFT) && last_step);
`else
  assign finish_other = ((state_q == IDLE) && accept && !start_shift) ||
                        ((state_q == SHIFT) && last_step);
`endif

  // One shift step; with use_carry the old carry is the fill, giving rotate-through-carry
  always_comb begin
    fill = uc_q ? carry_q : 1'b0;
    if (shl_q) begin
      shift_out = work_q[WIDTH-1];
      shifted   = {work_q[WIDTH-2:0], fill};
    end else begin
      shift_out = work_q[0];
      shifted   = {fill, work_q[WIDTH-1:1]};
    end
  end

`ifdef SEQ_ALU_MUL_EN
  // One shift-add multiply step: work_q holds the unconsumed multiplier bits, LSB first
  always_comb begin
    mul_sum  = {1'b0, mul_hi_q} + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mul_hi_d = mul_sum[WIDTH:1];
    mul_lo_d = {mul_sum[0], work_q[WIDTH-1:1]};
  end
`endif

  assign add_sum = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, use_carry & carry_q};
  assign sub_sum = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, (use_carry ? carry_q : 1'b1)};

  // Results of the ops that finish in one clock; shifts only reach here with a zero count
  always_comb begin
    sc_result = result;
    sc_carry  = carry_q;
    sc_cmp    = CMP_NONE;
    case (op)
      OP_AND:  begin sc_result = in_a & in_b; sc_carry = 1'b0; end
      OP_OR:   begin sc_result = in_a | in_b; sc_carry = 1'b0; end
      OP_XOR:  begin sc_result = in_a ^ in_b; sc_carry = 1'b0; end
      OP_ADD:  begin sc_result = add_sum[WIDTH-1:0]; sc_carry = add_sum[WIDTH]; end
      OP_SUB:  begin sc_result = sub_sum[WIDTH-1:0]; sc_carry = sub_sum[WIDTH]; end
      OP_MOVB: begin sc_result = in_b; sc_carry = 1'b0; end
      OP_MOVA: begin sc_result = in_a; sc_carry = 1'b0; end
      OP_CMP: begin
        if (in_a == in_b)     sc_cmp = CMP_EQ;
        else if (in_a > in_b) sc_cmp = CMP_GT;
        else                  sc_cmp = CMP_LT;
      end
      OP_SHL, OP_SHR: sc_result = in_a;
      OP_CLRC: sc_carry = 1'b0;
      default: begin sc_result = {WIDTH{1'b1}}; sc_carry = 1'b0; end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: leave IDLE only for iterative ops, return after the final step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_shift) state_d = SHIFT;
`ifdef SEQ_ALU_MUL_EN
        else if (start_mul) state_d = MUL;
`endif
      end
      SHIFT: if (last_step) state_d = IDLE;
`ifdef SEQ_ALU_MUL_EN
      MUL: if (last_step) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the unit accepts work only when idle
  always_comb begin
    ready = (state_q == IDLE);
  end

  // Datapath registers: operand capture, per-step updates and result/flag write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      work_q   <= '0;
      shl_q    <= 1'b0;
      uc_q     <= 1'b0;
      result   <= '0;
      carry_q  <= 1'b0;
      cmp_flag <= CMP_NONE;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_shift) begin
            cnt_q  <= shift_n;
            work_q <= in_a;
            shl_q  <= (op == OP_SHL);
            uc_q   <= use_carry;
          end
`ifdef SEQ_ALU_MUL_EN
          else if (start_mul) begin
            cnt_q  <= CNT_FULL;
            work_q <= in_b;
          end
`endif
          else if (accept) begin
            result   <= sc_result;
            carry_q  <= sc_carry;
            cmp_flag <= sc_cmp;
            done     <= 1'b1;
          end
        end
        SHIFT: begin
          work_q  <= shifted;
          carry_q <= shift_out;
          cnt_q   <= cnt_q - CNT_ONE;
          if (last_step) begin
            result   <= shifted;
            cmp_flag <= CMP_NONE;
            done     <= 1'b1;
          end
        end
`ifdef SEQ_ALU_MUL_EN
        MUL: begin
          work_q <= mul_lo_d;
          cnt_q  <= cnt_q - CNT_ONE;
          if (last_step) begin
            result   <= mul_lo_d;
            carry_q  <= 1'b0;
            cmp_flag <= CMP_NONE;
            done     <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SEQ_ALU_MUL_EN
  // Multiplier accumulator and upper product half; other completions clear result_hi
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mul_hi_q  <= '0;
      result_hi <= '0;
    end else begin
      if (start_mul) begin
        mcand_q  <= in_a;
        mul_hi_q <= '0;
      end else if (state_q == MUL) begin
        mul_hi_q <= mul_hi_d;
        if (last_step) result_hi <= mul_hi_d;
      end
      if (finish_other) result_hi <= '0;
    end
  end
`else
  logic unused_finish;
  assign unused_finish = finish_other;
  assign result_hi     = '0;
`endif

endmodule
